daq_event_packetizer: RTL and testbench
=======================================

Name: daq_event_packetizer

Overview:
- Downstream controller for the coincidence DAQ block. It captures each DAQ event record (time, per-channel peak and area) when the DAQ pulse rises.
- Records are queued in a small FIFO, then sequenced into a framed, checksummed byte stream for the UART transmitter using a valid/ready handshake.
- Raises a dead-time flag when the queue is full and counts events dropped because of it.

Parameters:
- N_CH, 2, number of detector channels per event
- N_T, 32, event time width; must be a multiple of 8, at most 32
- N_P, 12, signed peak width; at most 16; sign-extended to 2 bytes
- N_A, 20, signed area width; at most 24; sign-extended to 3 bytes
- FIFO_DEPTH, 4, number of event records buffered; power of 2, at least 2

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- event_pulse  input  1  DAQ pulse; a record is captured on its rising edge
- time_event  input  N_T  event time, sampled on the capture edge
- A_peak_event  input  signed N_P x N_CH  per-channel peak, sampled on the capture edge
- A_area_event  input  signed N_A x N_CH  per-channel area, sampled on the capture edge
- tx_ready  input  1  UART transmitter can accept a byte
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data is valid
- dead_time  output  1  FIFO full; the next event will be dropped
- fifo_level  output  clog2(FIFO_DEPTH)+1  number of records queued
- dropped_count  output  16  events lost while full; saturating
- frame_busy  output  1  a frame is being transmitted

Behaviour:
- Reset values: all outputs 0. FIFO emptied, FSM in IDLE, edge-detect register cleared.
- Reset mid-frame: tx_valid drops immediately. The partial frame is abandoned and is not resumed.
- Capture:
  - rise = event_pulse & ~event_pulse_d, where event_pulse_d is a registered copy.
  - On the clock edge where rise=1: if the FIFO is not full, push {time, peaks, areas} and increment fifo_level.
  - If the FIFO is full, discard the event and increment dropped_count. It saturates at 0xFFFF.
  - Full and a pop in the same cycle: the push is accepted, not dropped.
  - A level held high produces exactly one capture.
- dead_time = (fifo_level == FIFO_DEPTH), combinational from the registered level.
- Frame format, NB = 1 + N_T/8 + 5*N_CH + 1 bytes (16 at default):
  - byte 0: header 0xA5
  - time bytes, MSB first
  - for each channel ch = 0 .. N_CH-1: peak sign-extended to 16 bits (2 bytes, MSB first), then area sign-extended to 24 bits (3 bytes, MSB first)
  - final byte: checksum = XOR of all bytes after the header, excluding the checksum itself
- Handshake:
  - A byte transfers on a clock edge where tx_valid & tx_ready.
  - tx_valid, once high, stays high and tx_data stays stable until the transfer.
  - tx_valid is never raised without data; ready-before-valid is allowed.
- FSM:
  - IDLE: frame_busy=0. If fifo_level > 0, go to LOAD.
  - LOAD: pop the head record into the frame register, clear the checksum accumulator, set byte index=0, set frame_busy=1, then go to SEND.
  - SEND: tx_valid=1, tx_data = frame byte[index]. On transfer, fold the byte into the checksum if index > 0, and increment index. After byte NB-2 transfers, go to CSUM.
  - CSUM: tx_valid=1, tx_data = checksum. On transfer, go to IDLE.
- Latency and throughput:
  - First tx_valid of a frame asserts 2 cycles after the capture edge when the FSM is idle.
  - Back-to-back frames have a 2-cycle gap (IDLE, LOAD). With tx_ready held at 1, one byte transfers per cycle.
- Width rules:
  - fifo_level wraps never; it is bounded to 0..FIFO_DEPTH.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Sign extension uses the MSB of each field.

Test Plan:
- Single event, tx_ready=1 → frame A5 12 34 56 78 07 FF FF FF FF F8 00 00 00 10 E7.
  - Inputs: time=0x12345678, peak0=0x7FF, area0=0xFFFFF, peak1=0x800, area1=0x00010.
  - tx_valid first rises 2 cycles after the capture edge; 16 consecutive transfers; frame_busy falls after the checksum.
- Backpressure: tx_ready toggles 1,0,0,1 per byte → tx_data and tx_valid held stable through the low cycles; byte order and checksum identical to the first test.
- Overflow: 6 events captured while tx_ready=0 (FIFO_DEPTH=4) → fifo_level=4, dead_time=1, dropped_count=2; releasing ready emits 4 frames in capture order.
- Full with concurrent pop: FIFO full, then a rising edge on the same cycle as the LOAD pop → accepted, dropped_count unchanged, fifo_level stays 4.
- event_pulse held high for 3 cycles, twice → exactly 2 records captured; dropped_count=0.
- Reset asserted mid-frame at byte 5 → tx_valid=0, fifo_level=0, dropped_count=0 immediately. A new event after reset yields a complete frame starting with A5.

Source files
------------

// File: rtl/daq_event_packetizer.sv
// Queues DAQ event records and streams each one as a framed, XOR-checksummed byte packet.
// First byte is valid 2 cycles after capture; tx_valid holds with stable data while tx_ready is low.
module daq_event_packetizer #(
   parameter int N_CH       = 2,
   parameter int N_T        = 32,
   parameter int N_P        = 12,
   parameter int N_A        = 20,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          event_pulse,
   input  logic [N_T-1:0]                time_event,
   input  logic [N_CH*N_P-1:0]           A_peak_event,
   input  logic [N_CH*N_A-1:0]           A_area_event,
   input  logic                          tx_ready,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   output logic                          dead_time,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   dropped_count,
   output logic                          frame_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TB = N_T / 8;
   localparam int NB = 1 + TB + 5 * N_CH + 1;
   localparam int IW = $clog2(NB);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_CSUM} state_t;

   logic                 r_pulse_d;
   logic [N_T-1:0]       r_mem_t [FIFO_DEPTH];
   logic [N_CH*N_P-1:0]  r_mem_p [FIFO_DEPTH];
   logic [N_CH*N_A-1:0]  r_mem_a [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [LW-1:0]        r_level;
   logic [15:0]          r_dropped;

   state_t               r_state;
   logic [N_T-1:0]       r_rec_t;
   logic [N_CH*N_P-1:0]  r_rec_p;
   logic [N_CH*N_A-1:0]  r_rec_a;
   logic [IW-1:0]        r_idx;
   logic [7:0]           r_csum;
   logic [7:0]           r_tx_data;
   logic                 r_tx_valid;
   logic                 r_busy;

   logic                 w_rise;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic                 w_xfer;
   logic [7:0]           w_fb [NB];
   logic [7:0]           w_cur;
   logic [7:0]           w_nxt;
   logic [N_P-1:0]       w_pk;
   logic [N_A-1:0]       w_ar;
   logic [15:0]          w_pk16;
   logic [23:0]          w_ar24;

   assign w_rise = event_pulse & ~r_pulse_d;
   assign w_full = (r_level == LW'(FIFO_DEPTH));
   assign w_pop  = (r_state == S_LOAD);
   // A full queue still accepts a capture when the head leaves on the same edge.
   assign w_push = w_rise & (~w_full | w_pop);
   assign w_drop = w_rise & w_full & ~w_pop;
   assign w_xfer = r_tx_valid & tx_ready;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_t[r_wr_ptr] <= time_event;
         r_mem_p[r_wr_ptr] <= A_peak_event;
         r_mem_a[r_wr_ptr] <= A_area_event;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pulse_d <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_dropped <= '0;
      end else begin
         r_pulse_d <= event_pulse;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (w_drop && (r_dropped != 16'hFFFF))
            r_dropped <= r_dropped + 16'd1;
      end
   end

   // Frame bytes 0..NB-2 laid out from the held record; the last slot is never sent.
   always_comb begin
      w_pk   = '0;
      w_ar   = '0;
      w_pk16 = '0;
      w_ar24 = '0;
      for (int k = 0; k < NB; k++)
         w_fb[k] = 8'h00;
      w_fb[0] = 8'hA5;
      for (int k = 0; k < TB; k++)
         w_fb[1+k] = r_rec_t[N_T-1-8*k -: 8];
      for (int ch = 0; ch < N_CH; ch++) begin
         w_pk   = r_rec_p[ch*N_P +: N_P];
         w_ar   = r_rec_a[ch*N_A +: N_A];
         w_pk16 = 16'($signed(w_pk));
         w_ar24 = 24'($signed(w_ar));
         w_fb[1+TB+5*ch]   = w_pk16[15:8];
         w_fb[1+TB+5*ch+1] = w_pk16[7:0];
         w_fb[1+TB+5*ch+2] = w_ar24[23:16];
         w_fb[1+TB+5*ch+3] = w_ar24[15:8];
         w_fb[1+TB+5*ch+4] = w_ar24[7:0];
      end
   end

   assign w_cur = w_fb[r_idx];
   assign w_nxt = w_fb[r_idx + IW'(1)];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rec_t    <= '0;
         r_rec_p    <= '0;
         r_rec_a    <= '0;
         r_idx      <= '0;
         r_csum     <= '0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_level != '0)
                  r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_rec_t    <= r_mem_t[r_rd_ptr];
               r_rec_p    <= r_mem_p[r_rd_ptr];
               r_rec_a    <= r_mem_a[r_rd_ptr];
               r_csum     <= '0;
               r_idx      <= '0;
               r_busy     <= 1'b1;
               r_tx_valid <= 1'b1;
               r_tx_data  <= 8'hA5;
               r_state    <= S_SEND;
            end
            S_SEND: begin
               if (w_xfer) begin
                  r_idx <= r_idx + IW'(1);
                  if (r_idx != '0)
                     r_csum <= r_csum ^ w_cur;
                  // The checksum byte already includes the last data byte being handed over now.
                  if (r_idx == IW'(NB - 2)) begin
                     r_tx_data <= r_csum ^ w_cur;
                     r_state   <= S_CSUM;
                  end else begin
                     r_tx_data <= w_nxt;
                  end
               end
            end
            S_CSUM: begin
               if (w_xfer) begin
                  r_tx_valid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx_data       = r_tx_data;
   assign tx_valid      = r_tx_valid;
   assign frame_busy    = r_busy;
   assign fifo_level    = r_level;
   assign dropped_count = r_dropped;
   assign dead_time     = w_full;

endmodule

// File: tb/tb_daq_event_packetizer.sv
// Random and directed stimulus for daq_event_packetizer, checked every cycle against a queue-based model.
module tb_daq_event_packetizer;
   localparam int N_CH = 2;
   localparam int N_T = 32;
   localparam int N_P = 12;
   localparam int N_A = 20;
   localparam int DEPTH = 4;
   localparam int NB = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        event_pulse = 1'b0;
   logic [31:0] time_event = '0;
   logic [23:0] A_peak_event = '0;
   logic [39:0] A_area_event = '0;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        dead_time;
   logic [2:0]  fifo_level;
   logic [15:0] dropped_count;
   logic        frame_busy;

   daq_event_packetizer #(.N_CH(N_CH), .N_T(N_T), .N_P(N_P), .N_A(N_A), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .event_pulse(event_pulse), .time_event(time_event),
      .A_peak_event(A_peak_event), .A_area_event(A_area_event), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .dead_time(dead_time), .fifo_level(fifo_level),
      .dropped_count(dropped_count), .frame_busy(frame_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] t;
      logic [23:0] p;
      logic [39:0] a;
   } rec_t;
   typedef logic [7:0] bq_t [$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rdy_mode = 0;

   rec_t        m_q [$];
   bq_t         m_bytes;
   int          m_phase = 0;
   logic        m_prev = 1'b0;
   int          m_drop = 0;
   logic        m_rise;
   logic        m_popnow;
   int          m_sz;
   logic [7:0]  m_tmp;

   bq_t         got;
   logic        p_v = 1'b0;
   logic        p_r = 1'b0;
   logic [7:0]  p_d = '0;

   logic [7:0] lit [16] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h07, 8'hFF, 8'hFF,
                            8'hFF, 8'hFF, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h10, 8'hE7};
   localparam logic [31:0] SPEC_T = 32'h12345678;
   localparam logic [23:0] SPEC_P = {12'h800, 12'h7FF};
   localparam logic [39:0] SPEC_A = {20'h00010, 20'hFFFFF};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected wire image of one record: header, time MSB first, per-channel sign-extended fields, XOR.
   function automatic bq_t frame_of(input rec_t r);
      bq_t f;
      int v;
      logic [7:0] cs;
      f.push_back(8'hA5);
      for (int k = 3; k >= 0; k--)
         f.push_back(8'((r.t >> (8 * k)) & 32'hFF));
      for (int ch = 0; ch < N_CH; ch++) begin
         v = int'((r.p >> (ch * N_P)) & 24'hFFF);
         if (v >= 2048) v = v - 4096;
         f.push_back(8'((v >> 8) & 255));
         f.push_back(8'(v & 255));
         v = int'((r.a >> (ch * N_A)) & 40'hFFFFF);
         if (v >= 'h80000) v = v - 'h100000;
         f.push_back(8'((v >> 16) & 255));
         f.push_back(8'((v >> 8) & 255));
         f.push_back(8'(v & 255));
      end
      cs = 8'h00;
      for (int i = 1; i < f.size(); i++)
         cs = cs ^ f[i];
      f.push_back(cs);
      return f;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_bytes.delete();
         m_phase = 0;
         m_prev = 1'b0;
         m_drop = 0;
      end else begin
         m_rise = event_pulse & ~m_prev;
         m_prev = event_pulse;
         m_sz = m_q.size();
         m_popnow = (m_phase == 1);
         case (m_phase)
            0: if (m_sz > 0) m_phase = 1;
            1: begin
               m_bytes = frame_of(m_q.pop_front());
               m_phase = 2;
            end
            default: if (tx_ready) begin
               m_tmp = m_bytes.pop_front();
               if (m_bytes.size() == 0) m_phase = 0;
            end
         endcase
         if (m_rise) begin
            if (m_sz < DEPTH || m_popnow)
               m_q.push_back('{time_event, A_peak_event, A_area_event});
            else if (m_drop < 65535)
               m_drop++;
         end
      end
   end

   always @(negedge clk) begin
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_phase == 2});
      if (m_phase == 2 && m_bytes.size() > 0)
         chk("tx_data", {24'd0, tx_data}, {24'd0, m_bytes[0]});
      chk("frame_busy", {31'd0, frame_busy}, {31'd0, m_phase == 2});
      chk("fifo_level", {29'd0, fifo_level}, m_q.size());
      chk("dead_time", {31'd0, dead_time}, {31'd0, m_q.size() == DEPTH});
      chk("dropped_count", {16'd0, dropped_count}, m_drop);
      if (p_v && !p_r && !reset) begin
         chk("hold_valid", {31'd0, tx_valid}, 32'd1);
         chk("hold_data", {24'd0, tx_data}, {24'd0, p_d});
      end
      p_v = tx_valid & ~reset;
      p_r = tx_ready;
      p_d = tx_data;
      if (tx_valid && tx_ready && !reset)
         got.push_back(tx_data);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: tx_ready = ($urandom_range(0, 1) == 1);
            default: tx_ready = 1'b0;
         endcase
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got %0t expected earlier", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_event(input logic [31:0] t, input logic [23:0] p, input logic [39:0] a);
      time_event = t;
      A_peak_event = p;
      A_area_event = a;
      event_pulse = 1'b1;
      tick();
      event_pulse = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      repeat (3) tick();
      while ((fifo_level != 0 || frame_busy || tx_valid) && n < limit) begin
         tick();
         n++;
      end
      chk({name, "_idle_in_time"}, {31'd0, n < limit}, 32'd1);
   endtask

   task automatic chk_frame(input string name);
      chk({name, "_len"}, got.size(), NB);
      for (int i = 0; i < NB; i++)
         if (i < got.size())
            chk({name, "_byte"}, {24'd0, got[i]}, {24'd0, lit[i]});
   endtask

   initial begin
      bq_t mf;
      int n;
      rdy_mode = 0;
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_drop", {16'd0, dropped_count}, 32'd0);
      chk("rst_busy", {31'd0, frame_busy}, 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      mf = frame_of('{SPEC_T, SPEC_P, SPEC_A});
      for (int i = 0; i < NB; i++)
         chk("model_frame", {24'd0, mf[i]}, {24'd0, lit[i]});

      // Single event with ready held high
      got.delete();
      time_event = SPEC_T;
      A_peak_event = SPEC_P;
      A_area_event = SPEC_A;
      event_pulse = 1'b1;
      tick();
      event_pulse = 1'b0;
      n = 0;
      while (!tx_valid && n < 10) begin
         tick();
         n++;
      end
      chk("first_valid_latency", n, 32'd2);
      n = 0;
      while (frame_busy && n < 40) begin
         tick();
         n++;
      end
      chk("frame_cycles", n, 32'd16);
      wait_idle("t1", 100);
      chk_frame("t1");

      // Backpressure pattern
      rdy_mode = 1;
      got.delete();
      send_event(SPEC_T, SPEC_P, SPEC_A);
      wait_idle("t2", 200);
      chk_frame("t2");

      // Overflow behind a stalled frame, then a capture on the pop edge
      rdy_mode = 3;
      tick();
      send_event(32'h100, 24'h123456, 40'h12_3456_789A);
      n = 0;
      while (!frame_busy && n < 10) begin
         tick();
         n++;
      end
      chk("stall_busy", {31'd0, frame_busy}, 32'd1);
      for (int i = 0; i < 6; i++)
         send_event(32'h200 + i, 24'($urandom), 40'({$urandom, $urandom}));
      chk("ovf_level", {29'd0, fifo_level}, 32'd4);
      chk("ovf_dead", {31'd0, dead_time}, 32'd1);
      chk("ovf_drop", {16'd0, dropped_count}, 32'd2);
      rdy_mode = 0;
      n = 0;
      while (frame_busy && n < 60) begin
         tick();
         n++;
      end
      chk("stall_release", {31'd0, n < 60}, 32'd1);
      tick();
      time_event = 32'h300;
      event_pulse = 1'b1;
      tick();
      event_pulse = 1'b0;
      chk("concurrent_level", {29'd0, fifo_level}, 32'd4);
      chk("concurrent_drop", {16'd0, dropped_count}, 32'd2);
      wait_idle("drain", 500);

      // Reset in the middle of a frame
      got.delete();
      send_event(SPEC_T, SPEC_P, SPEC_A);
      n = 0;
      while (got.size() < 5 && n < 50) begin
         tick();
         n++;
      end
      chk("reach_byte5", {31'd0, n < 50}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
      chk("midrst_level", {29'd0, fifo_level}, 32'd0);
      chk("midrst_drop", {16'd0, dropped_count}, 32'd0);
      chk("midrst_busy", {31'd0, frame_busy}, 32'd0);
      got.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      send_event(SPEC_T, SPEC_P, SPEC_A);
      wait_idle("after_rst", 100);
      chk_frame("after_rst");

      // Level held high twice gives exactly two captures
      rdy_mode = 3;
      tick();
      event_pulse = 1'b1;
      repeat (3) tick();
      event_pulse = 1'b0;
      repeat (3) tick();
      event_pulse = 1'b1;
      repeat (3) tick();
      event_pulse = 1'b0;
      tick();
      chk("held_level", {29'd0, fifo_level}, 32'd1);
      chk("held_busy", {31'd0, frame_busy}, 32'd1);
      chk("held_drop", {16'd0, dropped_count}, 32'd0);
      rdy_mode = 0;
      wait_idle("held", 200);

      // Random traffic with random ready
      rdy_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            time_event = $urandom;
            A_peak_event = 24'($urandom);
            A_area_event = 40'({$urandom, $urandom});
            event_pulse = 1'b1;
         end else begin
            event_pulse = 1'b0;
         end
         tick();
      end
      event_pulse = 1'b0;
      rdy_mode = 0;
      wait_idle("random", 2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
